// File: rtl/fnd_scan_4digit_pkg.sv
// Shared definitions for the 4-digit FND scanner and the segment decoder.
// Holds the active-low segment glyphs ({dp,g,f,e,d,c,b,a}), the all-off
// patterns and the digit index type.
package fnd_scan_4digit_pkg;

    // Active-low glyphs, dp bit (bit 7) inactive.
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;   // shown for non-BCD nibbles
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] COM_OFF  = 4'hF;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/fnd_scan_4digit_seg.sv
// bcd_to_seg7: purely combinational BCD nibble to active-low 7-segment decoder.
// Ports: nibble [3:0] in, blank in (force segments a..g off), dp in (1 = light dp),
//        seg [7:0] out {dp,g,f,e,d,c,b,a}, active-low. Nibbles 10..15 show a dash.
module bcd_to_seg7
    import fnd_scan_4digit_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [6:0] w_glyph;

    always_comb begin
        w_glyph = SEG_DASH[6:0];
        case (nibble)
            4'd0:    w_glyph = SEG_0[6:0];
            4'd1:    w_glyph = SEG_1[6:0];
            4'd2:    w_glyph = SEG_2[6:0];
            4'd3:    w_glyph = SEG_3[6:0];
            4'd4:    w_glyph = SEG_4[6:0];
            4'd5:    w_glyph = SEG_5[6:0];
            4'd6:    w_glyph = SEG_6[6:0];
            4'd7:    w_glyph = SEG_7[6:0];
            4'd8:    w_glyph = SEG_8[6:0];
            4'd9:    w_glyph = SEG_9[6:0];
            default: w_glyph = SEG_DASH[6:0];
        endcase
    end

    // dp is independent of blanking so a blanked digit can still show its point.
    assign seg = {~dp, (blank ? 7'h7F : w_glyph)};

endmodule

// File: rtl/fnd_scan_4digit.sv
// fnd_scan_4digit: time-multiplexed driver for a 4-digit common-anode FND.
// Ports: clk, reset_p (async active-high), bcd[15:0] packed BCD (thousands..units),
//        dp_en[3:0] per-digit dp, blank_lz leading-zero blanking (live),
//        com[3:0] active-low commons (com[0] = units), seg_7[7:0] active-low {dp,g..a}.
// Outputs are registered (1 cycle after the scan state); bcd/dp_en are captured
// once per frame so a frame never mixes two input words.
module fnd_scan_4digit
    import fnd_scan_4digit_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,   // clk cycles per digit slot, >= 2
    parameter int GUARD    = 8          // all-off cycles at slot start, < SCAN_DIV
)(
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  com,
    output logic [7:0]  seg_7
);

    localparam int               CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [15:0]      r_snap_bcd;
    logic [3:0]       r_snap_dp;
    logic [3:0]       r_com;
    logic [7:0]       r_seg;

    logic             w_tick;
    logic             w_guard;
    logic [3:0]       w_nib;
    logic [3:1]       w_zero;
    logic [3:0]       w_lz;
    logic             w_blank;
    logic [7:0]       w_seg;

    assign w_tick  = (r_cnt == CNT_MAX);
    assign w_guard = (int'(r_cnt) < GUARD);
    assign w_nib   = r_snap_bcd[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every more significant nibble are 0.
    // Non-BCD nibbles compare as non-zero, so they stop the blanking run.
    always_comb begin
        for (int i = 1; i < 4; i++) begin
            w_zero[i] = (r_snap_bcd[4*i +: 4] == 4'd0);
        end
        w_lz[3] = w_zero[3];
        w_lz[2] = w_zero[3] & w_zero[2];
        w_lz[1] = w_zero[3] & w_zero[2] & w_zero[1];
        w_lz[0] = 1'b0;                     // units digit always shown
    end

    assign w_blank = blank_lz & w_lz[r_idx];

    bcd_to_seg7 u_dec (
        .nibble (w_nib),
        .blank  (w_blank),
        .dp     (r_snap_dp[r_idx]),
        .seg    (w_seg)
    );

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap_bcd <= '0;
            r_snap_dp  <= '0;
            r_com      <= COM_OFF;
            r_seg      <= SEG_OFF;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
                // Capture at the end of the last slot so the new frame starts clean.
                if (r_idx == 2'd3) begin
                    r_snap_bcd <= bcd;
                    r_snap_dp  <= dp_en;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_guard) begin
                r_com <= COM_OFF;
                r_seg <= SEG_OFF;
            end else begin
                r_com <= ~(4'b0001 << r_idx);
                r_seg <= w_seg;
            end
        end
    end

    assign com   = r_com;
    assign seg_7 = r_seg;

endmodule
